data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Data-side memory responder for the 5-stage pipeline: sits on the CPU's DATA_MEM_* interface, serving the MEM stage.
- Loads: single-cycle combinational read with byte/half/word selection and sign/zero extension.
- Stores: byte-lane writes on the clock edge.
- Detects misaligned accesses and records the first one in a sticky fault register; optional load/store performance counters.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array.
- ADDR_W, 10, word-index width; must equal log2(DEPTH).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ADDRESS  input  32  byte address from the CPU (DATA_MEM_ADDRESS).
- WRITEDATA  input  32  store data, right-aligned (DATA_MEM_WRITEDATA).
- READ_WRITE_EN  input  4  access code, see Behaviour.
- READDATA  output  32  extended load data (DATA_MEM_READDATA).
- MISALIGN_FLAG  output  1  sticky: a misaligned access has occurred.
- FAULT_ADDRESS  output  32  byte address of the first misaligned access.
- LOAD_COUNT  output  32  completed loads (only with DMEM_PERF_CNT_EN).
- STORE_COUNT  output  32  completed stores (only with DMEM_PERF_CNT_EN).

Behaviour:
- Clock and reset: one clock, CLK; reset is asynchronous and active-high, port RESET.
- Access code READ_WRITE_EN:
  - 0000 idle.
  - Loads: 1000 LB, 1001 LH, 1010 LW, 1100 LBU, 1101 LHU.
  - Stores: 0001 SB, 0010 SH, 0011 SW.
  - Any other code is treated as idle: no write, READDATA=0, no flag.
- Indexing:
  - Word index = ADDRESS[ADDR_W+1:2]; higher address bits are ignored, so accesses wrap modulo DEPTH words.
  - Byte lane = ADDRESS[1:0]; lane 0 is bits [7:0] (little-endian).
- Alignment:
  - Byte accesses are always aligned.
  - Halfword accesses require ADDRESS[0]=0.
  - Word accesses require ADDRESS[1:0]=00.
- Loads, zero latency (combinational from ADDRESS, READ_WRITE_EN and array contents):
  - LB/LBU select the addressed byte, sign- or zero-extended.
  - LH/LHU select halfword ADDRESS[1], sign- or zero-extended.
  - LW returns the whole word.
- READDATA=0 when:
  - idle or illegal code,
  - the access is misaligned,
  - RESET=1.
- Stores, committed at the rising edge:
  - SB writes WRITEDATA[7:0] to the addressed lane only.
  - SH writes WRITEDATA[15:0] to lanes {1,0} or {3,2}.
  - SW writes all four lanes.
  - Unselected lanes are unchanged.
- Read-after-write:
  - A load in the cycle after a store to the same word returns the new data.
  - A load and a store never occur in the same cycle (single port).
- Misaligned load or store:
  - The array is not written.
  - MISALIGN_FLAG is set at the next edge.
  - FAULT_ADDRESS captures ADDRESS only if MISALIGN_FLAG was 0 beforehand (first fault wins).
  - Both hold until RESET.
- Reset values:
  - MISALIGN_FLAG=0, FAULT_ADDRESS=0, LOAD_COUNT=0, STORE_COUNT=0.
  - Array contents are not cleared by reset.
- Reset mid-access: a store whose edge coincides with RESET=1 is discarded.
- No handshake: every legal access completes in its cycle. The block never stalls the pipeline.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined:
  - LOAD_COUNT increments at each edge with a legal, aligned load.
  - STORE_COUNT increments at each edge with a legal, aligned store.
  - Both wrap 0xFFFFFFFF->0 and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- SW 0x12345678 @0x100, then LW @0x100 -> READDATA=0x12345678.
- SB 0xAB @0x101, then LW @0x100 -> 0x1234AB78; LB @0x101 -> 0xFFFFFFAB; LBU @0x101 -> 0x000000AB.
- SH 0x8001 @0x102, then LH @0x102 -> 0xFFFF8001; LHU @0x102 -> 0x00008001; LW @0x100 -> 0x8001AB78.
- SW @0x105 (misaligned), then SW @0x203 -> word @0x104 unchanged, READDATA=0 during the access, MISALIGN_FLAG=1 next cycle, FAULT_ADDRESS=0x105 (not 0x203).
- Store with RESET pulsed mid-cycle -> store discarded, flag/counters=0; prior array contents retained; access with ADDRESS=0x1000+4*DEPTH -> aliases word 0x1000>>2.
- With DMEM_PERF_CNT_EN: 3 loads, 2 stores, 1 misaligned load, 1 code 1111 -> LOAD_COUNT=3, STORE_COUNT=2; preload counter to 0xFFFFFFFF via force, one load -> 0.

Source files
------------

// File: rtl/data_memory_if.sv
// Data-side memory bus between the CPU MEM stage (master) and data_memory (slave).
// LOAD_COUNT/STORE_COUNT only carry live values when DMEM_PERF_CNT_EN is defined.
interface data_memory_if;
  logic [31:0] ADDRESS;
  logic [31:0] WRITEDATA;
  logic [3:0]  READ_WRITE_EN;
  logic [31:0] READDATA;
  logic        MISALIGN_FLAG;
  logic [31:0] FAULT_ADDRESS;
  logic [31:0] LOAD_COUNT;
  logic [31:0] STORE_COUNT;

  modport master (
    output ADDRESS, WRITEDATA, READ_WRITE_EN,
    input  READDATA, MISALIGN_FLAG, FAULT_ADDRESS, LOAD_COUNT, STORE_COUNT
  );

  modport slave (
    input  ADDRESS, WRITEDATA, READ_WRITE_EN,
    output READDATA, MISALIGN_FLAG, FAULT_ADDRESS, LOAD_COUNT, STORE_COUNT
  );
endinterface

// File: rtl/data_memory.sv
// Single-port data memory: combinational byte/half/word loads, byte-lane stores, sticky misalign fault.
// Optional load/store performance counters are built only when DMEM_PERF_CNT_EN is defined.
module data_memory #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic          CLK,
  input  logic          RESET,
  data_memory_if.slave  bus
);

  localparam logic [1:0] SZ_NONE = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  logic [31:0]       mem_r [DEPTH];
  logic [ADDR_W-1:0] word_idx_s;
  logic [1:0]        lane_s;
  logic              is_load_s;
  logic              is_store_s;
  logic              sign_s;
  logic [1:0]        size_s;
  logic              misalign_s;
  logic              load_ok_s;
  logic              store_ok_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s;
  logic [31:0]       rd_word_s;
  logic [7:0]        rd_byte_s;
  logic [15:0]       rd_half_s;
  logic [31:0]       readdata_s;
  logic              flag_r;
  logic [31:0]       fault_r;

  assign word_idx_s = bus.ADDRESS[ADDR_W+1:2];
  assign lane_s     = bus.ADDRESS[1:0];

  // Decode the access code into direction, size and signedness; unknown codes stay idle.
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    sign_s     = 1'b0;
    size_s     = SZ_NONE;
    case (bus.READ_WRITE_EN)
      4'b1000: begin is_load_s  = 1'b1; size_s = SZ_BYTE; sign_s = 1'b1; end
      4'b1001: begin is_load_s  = 1'b1; size_s = SZ_HALF; sign_s = 1'b1; end
      4'b1010: begin is_load_s  = 1'b1; size_s = SZ_WORD; end
      4'b1100: begin is_load_s  = 1'b1; size_s = SZ_BYTE; end
      4'b1101: begin is_load_s  = 1'b1; size_s = SZ_HALF; end
      4'b0001: begin is_store_s = 1'b1; size_s = SZ_BYTE; end
      4'b0010: begin is_store_s = 1'b1; size_s = SZ_HALF; end
      4'b0011: begin is_store_s = 1'b1; size_s = SZ_WORD; end
      default: begin is_load_s  = 1'b0; end
    endcase
  end

  assign misalign_s = ((size_s == SZ_HALF) && bus.ADDRESS[0]) ||
                      ((size_s == SZ_WORD) && (bus.ADDRESS[1:0] != 2'b00));
  assign load_ok_s  = is_load_s  && !misalign_s;
  assign store_ok_s = is_store_s && !misalign_s;

  // Replicate store data onto every lane and pick the lanes to enable.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = bus.WRITEDATA;
    case (size_s)
      SZ_BYTE: begin
        be_s    = 4'b0001 << lane_s;
        wdata_s = {4{bus.WRITEDATA[7:0]}};
      end
      SZ_HALF: begin
        be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{bus.WRITEDATA[15:0]}};
      end
      SZ_WORD: be_s = 4'b1111;
      default: be_s = 4'b0000;
    endcase
  end

  // Array write; an edge that sees RESET high discards the store, contents are never cleared.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
    end else if (store_ok_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[word_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign rd_word_s = mem_r[word_idx_s];
  assign rd_byte_s = rd_word_s[8*lane_s +: 8];
  assign rd_half_s = lane_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];

  // Combinational load path with extension; zero on reset, idle, store or misaligned access.
  always_comb begin
    readdata_s = 32'h0000_0000;
    if (RESET || !load_ok_s) begin
      readdata_s = 32'h0000_0000;
    end else if (size_s == SZ_BYTE) begin
      readdata_s = {{24{sign_s & rd_byte_s[7]}}, rd_byte_s};
    end else if (size_s == SZ_HALF) begin
      readdata_s = {{16{sign_s & rd_half_s[15]}}, rd_half_s};
    end else begin
      readdata_s = rd_word_s;
    end
  end

  // Sticky fault capture: the first misaligned address wins until reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      flag_r  <= 1'b0;
      fault_r <= 32'h0000_0000;
    end else if (misalign_s) begin
      flag_r <= 1'b1;
      if (!flag_r) begin
        fault_r <= bus.ADDRESS;
      end
    end
  end

  assign bus.READDATA      = readdata_s;
  assign bus.MISALIGN_FLAG = flag_r;
  assign bus.FAULT_ADDRESS = fault_r;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] load_count_r;
  logic [31:0] store_count_r;

  // Completed-access counters, free-running with natural 32-bit wrap.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      load_count_r  <= 32'h0000_0000;
      store_count_r <= 32'h0000_0000;
    end else begin
      if (load_ok_s) begin
        load_count_r <= load_count_r + 32'd1;
      end
      if (store_ok_s) begin
        store_count_r <= store_count_r + 32'd1;
      end
    end
  end

  assign bus.LOAD_COUNT  = load_count_r;
  assign bus.STORE_COUNT = store_count_r;
`else
  assign bus.LOAD_COUNT  = 32'h0000_0000;
  assign bus.STORE_COUNT = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed test-plan steps followed by randomized accesses,
// all checked against a byte-addressed reference model of the memory and fault/counter state.
module tb_data_memory;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;
`ifdef DMEM_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [3:0] LB = 4'b1000, LH = 4'b1001, LW = 4'b1010, LBU = 4'b1100, LHU = 4'b1101;
  localparam logic [3:0] SB = 4'b0001, SH = 4'b0010, SW = 4'b0011, IDLE = 4'b0000;

  logic clk;
  logic rst;
  data_memory_if bus();

  data_memory #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem_b [4*DEPTH];
  logic        m_flag;
  logic [31:0] m_fault;
  logic [31:0] m_lc;
  logic [31:0] m_sc;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [3:0] c);
    case (c)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] c, input logic [31:0] a);
    int sz;
    int base;
    longint unsigned v;
    sz = size_of(c);
    v  = 0;
    if (!c[3] || sz == 0 || (a % sz) != 0) return 32'h0;
    base = int'(a % (4 * DEPTH));
    for (int k = 0; k < sz; k++) v += 64'(mem_b[base + k]) << (8 * k);
    if ((c == LB || c == LH) && v >= (64'd1 << (8 * sz - 1)))
      v = v + 64'h1_0000_0000 - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  function automatic void model_commit(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd);
    int sz;
    int base;
    sz = size_of(c);
    if (sz == 0) return;
    if ((a % sz) != 0) begin
      if (!m_flag) m_fault = a;
      m_flag = 1'b1;
    end else if (c[3]) begin
      m_lc = m_lc + 32'd1;
    end else begin
      base = int'(a % (4 * DEPTH));
      for (int k = 0; k < sz; k++) mem_b[base + k] = 8'((wd >> (8 * k)) & 32'hFF);
      m_sc = m_sc + 32'd1;
    end
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_flag"},  {31'd0, bus.MISALIGN_FLAG}, {31'd0, m_flag});
    check({tag, "_fault"}, bus.FAULT_ADDRESS, m_fault);
    check({tag, "_lcnt"},  bus.LOAD_COUNT,  PERF ? m_lc : 32'h0);
    check({tag, "_scnt"},  bus.STORE_COUNT, PERF ? m_sc : 32'h0);
  endtask

  task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.READ_WRITE_EN = c;
    bus.ADDRESS       = a;
    bus.WRITEDATA     = wd;
    #1;
    last_rd = bus.READDATA;
    check("readdata", last_rd, model_read(c, a));
    @(posedge clk);
    model_commit(c, a, wd);
    #1;
    check_state("post_edge");
  endtask

  task automatic reset_pulse(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.READ_WRITE_EN = c;
    bus.ADDRESS       = a;
    bus.WRITEDATA     = wd;
    rst = 1'b1;
    m_flag = 1'b0; m_fault = 32'h0; m_lc = 32'h0; m_sc = 32'h0;
    #1;
    check("rst_readdata", bus.READDATA, 32'h0);
    check_state("in_reset");
    @(posedge clk);
    #1;
    check_state("reset_edge");
    @(negedge clk);
    rst = 1'b0;
    bus.READ_WRITE_EN = IDLE;
  endtask

  initial begin
    logic [3:0] codes [9];
    logic [3:0] c;
    logic [31:0] a;
    codes = '{LB, LH, LW, LBU, LHU, SB, SH, SW, IDLE};
    rst = 1'b1;
    bus.READ_WRITE_EN = IDLE;
    bus.ADDRESS = 32'h0;
    bus.WRITEDATA = 32'h0;
    m_flag = 1'b0; m_fault = 32'h0; m_lc = 32'h0; m_sc = 32'h0;
    #1;
    check("reset_readdata", bus.READDATA, 32'h0);
    check_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill the low 256 words so every later load reads known data.
    for (int i = 0; i < 256; i++) op(SW, 32'(i * 4), $urandom);

    op(SW, 32'h100, 32'h1234_5678);
    op(LW, 32'h100, 32'h0);          check("lw_100",  last_rd, 32'h1234_5678);
    op(SB, 32'h101, 32'h0000_00AB);
    op(LW, 32'h100, 32'h0);          check("lw_sb",   last_rd, 32'h1234_AB78);
    op(LB, 32'h101, 32'h0);          check("lb_101",  last_rd, 32'hFFFF_FFAB);
    op(LBU, 32'h101, 32'h0);         check("lbu_101", last_rd, 32'h0000_00AB);
    op(SH, 32'h102, 32'h0000_8001);
    op(LH, 32'h102, 32'h0);          check("lh_102",  last_rd, 32'hFFFF_8001);
    op(LHU, 32'h102, 32'h0);         check("lhu_102", last_rd, 32'h0000_8001);
    op(LW, 32'h100, 32'h0);          check("lw_sh",   last_rd, 32'h8001_AB78);

    reset_pulse(IDLE, 32'h0, 32'h0);
    op(SW, 32'h105, 32'hDEAD_BEEF);  check("mis_rd",  last_rd, 32'h0);
    check("mis_flag", {31'd0, bus.MISALIGN_FLAG}, 32'd1);
    op(SW, 32'h203, 32'hFEED_FACE);  check("first_fault", bus.FAULT_ADDRESS, 32'h105);
    op(LW, 32'h104, 32'h0);
    op(LH, 32'h201, 32'h0);          check("mis_lh_rd", last_rd, 32'h0);

    reset_pulse(SW, 32'h100, 32'hDEAD_BEEF);
    op(LW, 32'h100, 32'h0);          check("rst_store_dropped", last_rd, 32'h8001_AB78);
    op(SW, 32'h1000 + 4 * DEPTH, 32'hCAFE_F00D);
    op(LW, 32'h1000, 32'h0);         check("alias", last_rd, 32'hCAFE_F00D);

    reset_pulse(IDLE, 32'h0, 32'h0);
    op(LW, 32'h10, 32'h0);
    op(LB, 32'h13, 32'h0);
    op(LHU, 32'h16, 32'h0);
    op(SB, 32'h21, 32'h0000_0055);
    op(SW, 32'h24, 32'h0BAD_CAFE);
    op(LW, 32'h2, 32'h0);
    op(4'b1111, 32'h40, 32'h0);
    check("load_count3",  bus.LOAD_COUNT,  PERF ? 32'd3 : 32'd0);
    check("store_count2", bus.STORE_COUNT, PERF ? 32'd2 : 32'd0);
`ifdef DMEM_PERF_CNT_EN
    @(negedge clk);
    force dut.load_count_r = 32'hFFFF_FFFF;
    #1;
    release dut.load_count_r;
    m_lc = 32'hFFFF_FFFF;
    op(LW, 32'h10, 32'h0);
    check("load_count_wrap", bus.LOAD_COUNT, 32'h0);
`endif

    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 50) reset_pulse(SW, $urandom & 32'hFFFF_F3FF, $urandom);
      c = ($urandom_range(0, 4) == 0) ? 4'($urandom) : codes[$urandom_range(0, 8)];
      a = $urandom & 32'hFFFF_F3FF;
      op(c, a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
